// File: rtl/fir_sched_pkg.sv
// Shared sizes and types for the time-multiplexed FIR MAC scheduler.
package fir_sched_pkg;

   localparam int unsigned NTAPS  = 16;
   localparam int unsigned DATA_W = 18;
   localparam int unsigned COEF_W = 10;
   localparam int unsigned PROD_W = 28;
   localparam int unsigned TAP_W  = $clog2(NTAPS);
   // Headroom for NTAPS full-scale products.
   localparam int unsigned ACC_W  = PROD_W + TAP_W;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   typedef logic [TAP_W-1:0] tap_idx_t;

endpackage

// File: rtl/fir_coef_regfile.sv
// Coefficient register file: one gated write port, one combinational read port.
module fir_coef_regfile
   import fir_sched_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  tap_idx_t          waddr_i,
   input  logic [COEF_W-1:0] wdata_i,
   input  tap_idx_t          raddr_i,
   output logic [COEF_W-1:0] rdata_o
);

   logic [COEF_W-1:0] coef_q [NTAPS];

   // Coefficient storage, cleared on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
      end else if (we_i) begin
         coef_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = coef_q[raddr_i];

endmodule

// File: rtl/fir_mac_scheduler.sv
// FIR tap scheduler: feeds one shared multiplier one tap per cycle and accumulates.
module fir_mac_scheduler
   import fir_sched_pkg::*;
(
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic signed [DATA_W-1:0] x_data,
   input  logic                     x_valid,
   output logic                     x_ready,
   output logic signed [ACC_W-1:0]  y_data,
   output logic                     y_valid,
   input  logic                     y_ready,
   input  logic                     cfg_we,
   input  tap_idx_t                 cfg_addr,
   input  logic [COEF_W-1:0]        cfg_data,
   output logic                     cfg_ready,
   output logic signed [DATA_W-1:0] mul_a,
   output logic [COEF_W-1:0]        mul_b,
   input  logic signed [PROD_W-1:0] mul_p
);

   state_t                   state_q, state_d;
   logic                     ready_q;
   logic                     accept, last_tap;
   tap_idx_t                 tap_q, tap_nxt, wr_ptr_q, samp_idx, coef_ridx;
   logic signed [ACC_W-1:0]  acc_q, acc_nxt;
   logic signed [DATA_W-1:0] dline_q [NTAPS];
   logic [COEF_W-1:0]        coef_rd;

   fir_coef_regfile u_coef (
      .clk_i   (ap_clk),
      .rst_ni  (ap_rst_n),
      .we_i    (cfg_we & ready_q),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data),
      .raddr_i (coef_ridx),
      .rdata_o (coef_rd)
   );

   // State register; ready_q tracks IDLE but stays low through the first cycle after reset.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == IDLE);
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)   state_d = MAC;
         MAC:     if (last_tap) state_d = OUT;
         OUT:     if (y_ready)  state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // Output and datapath control decode.
   always_comb begin
      x_ready   = ready_q;
      cfg_ready = ready_q;
      accept    = x_valid & ready_q;
      last_tap  = (state_q == MAC) && (tap_q == tap_idx_t'(NTAPS - 1));
      tap_nxt   = tap_q + tap_idx_t'(1);
      // Tap k+1 reads the sample k+1 positions older than the newest one.
      samp_idx  = wr_ptr_q - tap_nxt;
      coef_ridx = (state_q == MAC) ? tap_nxt : '0;
      acc_nxt   = acc_q + {{(ACC_W - PROD_W){mul_p[PROD_W-1]}}, mul_p};
   end

   // Delay line, operand registers, accumulator and output registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < NTAPS; i++) dline_q[i] <= '0;
         wr_ptr_q <= '0;
         tap_q    <= '0;
         acc_q    <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
         y_data   <= '0;
         y_valid  <= 1'b0;
      end else if (accept) begin
         dline_q[wr_ptr_q] <= x_data;
         acc_q             <= '0;
         tap_q             <= '0;
         mul_a             <= x_data;
         mul_b             <= coef_rd;
      end else if (state_q == MAC) begin
         acc_q <= acc_nxt;
         tap_q <= tap_nxt;
         mul_a <= dline_q[samp_idx];
         mul_b <= coef_rd;
         if (last_tap) begin
            y_data   <= acc_nxt;
            y_valid  <= 1'b1;
            wr_ptr_q <= wr_ptr_q + tap_idx_t'(1);
         end
      end else if ((state_q == OUT) && y_ready) begin
         y_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler with a transaction-level FIR model.
module tb_fir_mac_scheduler;
   import fir_sched_pkg::*;

   logic                     ap_clk = 1'b0;
   logic                     ap_rst_n = 1'b0;
   logic signed [DATA_W-1:0] x_data = '0;
   logic                     x_valid = 1'b0;
   logic                     x_ready;
   logic signed [ACC_W-1:0]  y_data;
   logic                     y_valid;
   logic                     y_ready = 1'b0;
   logic                     cfg_we = 1'b0;
   tap_idx_t                 cfg_addr = '0;
   logic [COEF_W-1:0]        cfg_data = '0;
   logic                     cfg_ready;
   logic signed [DATA_W-1:0] mul_a;
   logic [COEF_W-1:0]        mul_b;
   logic signed [PROD_W-1:0] mul_p;
   longint                   mul_full;

   int checks = 0;
   int errors = 0;

   fir_mac_scheduler dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .x_data    (x_data),
      .x_valid   (x_valid),
      .x_ready   (x_ready),
      .y_data    (y_data),
      .y_valid   (y_valid),
      .y_ready   (y_ready),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p)
   );

   always #5 ap_clk = ~ap_clk;

   // Shared multiplier: signed sample times zero-extended coefficient.
   always_comb mul_full = longint'(mul_a) * longint'({1'b0, mul_b});
   assign mul_p = mul_full[PROD_W-1:0];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int     m_phase = 0;   // 0 waiting for sample, 1 computing, 2 presenting
   int     m_cnt = 0;
   bit     m_ready = 1'b0;
   bit     m_yv = 1'b0;
   longint m_y = 0;
   longint m_yd = 0;
   longint m_hist [NTAPS];
   longint m_coef [NTAPS];

   // Compare DUT against the model, then advance the model over the coming edge.
   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         check("rst_x_ready", x_ready, 0);
         check("rst_cfg_ready", cfg_ready, 0);
         check("rst_y_valid", y_valid, 0);
         check("rst_y_data", y_data, 0);
         check("rst_mul_a", mul_a, 0);
         check("rst_mul_b", mul_b, 0);
         m_phase = 0; m_cnt = 0; m_ready = 0; m_yv = 0; m_y = 0; m_yd = 0;
         for (int i = 0; i < NTAPS; i++) begin
            m_hist[i] = 0;
            m_coef[i] = 0;
         end
      end else begin
         bit was_ready;
         check("x_ready", x_ready, m_ready);
         check("cfg_ready", cfg_ready, m_ready);
         check("y_valid", y_valid, m_yv);
         check("y_data", y_data, m_yd);
         was_ready = m_ready;
         case (m_phase)
            0: begin
               if (m_ready && x_valid) begin
                  for (int i = NTAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                  m_hist[0] = x_data;
                  m_y = 0;
                  for (int i = 0; i < NTAPS; i++) m_y += m_coef[i] * m_hist[i];
                  m_phase = 1;
                  m_cnt = NTAPS;
                  m_ready = 0;
               end else begin
                  m_ready = 1;
               end
            end
            1: begin
               m_cnt--;
               if (m_cnt == 0) begin
                  m_phase = 2;
                  m_yv = 1;
                  m_yd = m_y;
               end
            end
            default: begin
               if (y_ready) begin
                  m_phase = 0;
                  m_yv = 0;
                  m_ready = 1;
               end
            end
         endcase
         if (cfg_we && was_ready) m_coef[cfg_addr] = cfg_data;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic cfg_write(input int a, input int d);
      cfg_addr = tap_idx_t'(a);
      cfg_data = COEF_W'(d);
      cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic send(input logic signed [DATA_W-1:0] v);
      int n = 0;
      x_data = v;
      x_valid = 1'b1;
      while (!x_ready && n < 200) begin
         step();
         n++;
      end
      if (!x_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got x_ready=0, expected 1 within 200 cycles");
      end
      step();
      x_valid = 1'b0;
   endtask

   task automatic recv(input int stall, output longint y);
      int n = 0;
      while (!y_valid && n < 200) begin
         step();
         n++;
      end
      if (!y_valid) begin
         checks++;
         errors++;
         $display("FAIL recv_timeout: got y_valid=0, expected 1 within 200 cycles");
         y = 0;
         return;
      end
      y = y_data;
      for (int i = 0; i < stall; i++) begin
         step();
         check("bp_y_stable", y_data, y);
         check("bp_y_valid_held", y_valid, 1);
         check("bp_x_ready_low", x_ready, 0);
      end
      y_ready = 1'b1;
      step();
      y_ready = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      longint y;
      repeat (3) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      step();
      step();

      // Impulse response: coef[i] = i+1.
      for (int i = 0; i < NTAPS; i++) cfg_write(i, i + 1);
      for (int n = 0; n <= NTAPS; n++) begin
         send((n == 0) ? 18'sd1 : 18'sd0);
         recv(0, y);
         check("impulse", y, (n < NTAPS) ? n + 1 : 0);
      end

      // Full-scale negative input with maximum coefficients.
      for (int i = 0; i < NTAPS; i++) cfg_write(i, 1023);
      for (int n = 0; n < NTAPS; n++) begin
         send(-18'sd131072);
         recv(0, y);
      end
      check("full_scale_neg", y, -64'sd2145386496);

      // Backpressure: output held five cycles.
      send(18'sd5);
      recv(5, y);
      check("bp_value", y, -64'sd2011294725);
      check("bp_x_ready_after", x_ready, 1);

      // Configuration lockout during MAC, then an accepted write in IDLE.
      for (int i = 0; i < NTAPS; i++) cfg_write(i, i + 1);
      for (int n = 0; n < NTAPS; n++) begin
         send(18'sd0);
         recv(0, y);
      end
      send(18'sd1);
      cfg_write(3, 7);
      recv(0, y);
      check("lock_y0", y, 1);
      send(18'sd0); recv(0, y); check("lock_y1", y, 2);
      send(18'sd0); recv(0, y); check("lock_y2", y, 3);
      send(18'sd0); recv(0, y); check("lock_coef3_kept", y, 4);
      cfg_write(3, 7);
      send(18'sd1); recv(0, y); check("cfg_y0", y, 6);
      send(18'sd0); recv(0, y); check("cfg_y1", y, 8);
      send(18'sd0); recv(0, y); check("cfg_y2", y, 10);
      send(18'sd0); recv(0, y); check("cfg_new_coef3", y, 15);

      // Wraparound with random samples; the model checks every output.
      for (int n = 0; n < 40; n++) begin
         logic signed [DATA_W-1:0] r;
         r = DATA_W'($urandom);
         send(r);
         recv(int'($urandom_range(0, 2)), y);
      end

      // Reset while presenting: y_valid must drop without a clock edge.
      send(18'sd9);
      begin
         int n = 0;
         while (!y_valid && n < 200) begin
            step();
            n++;
         end
      end
      check("out_valid_before_rst", y_valid, 1);
      ap_rst_n = 1'b0;
      #1;
      check("rst_out_y_valid", y_valid, 0);
      check("rst_out_y_data", y_data, 0);
      step();
      ap_rst_n = 1'b1;
      step();
      step();

      // Reset at MAC cycle 5, then a clean impulse.
      send(18'sd3);
      repeat (5) step();
      ap_rst_n = 1'b0;
      #1;
      check("rst_mac_y_valid", y_valid, 0);
      check("rst_mac_x_ready", x_ready, 0);
      step();
      ap_rst_n = 1'b1;
      step();
      step();
      cfg_write(0, 2);
      send(18'sd1);
      recv(0, y);
      check("post_rst_impulse", y, 2);

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
